// File: rtl/lsu_pkg.sv
// Shared load/store unit types: access sizes, store FSM states and the
// byte-mask helper used for lane alignment.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BEAT0  = 2'b01,
        ST_BEAT1  = 2'b10,
        ST_FINISH = 2'b11
    } store_state_t;

    localparam int WORD_BYTES = 4;

    // Reserved size encoding 2'b11 is treated as a full word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001;
            SZ_H:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_write_port_if.sv
// Store request channel plus data-memory write bus of the store write port.
interface store_write_port_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
    );
endinterface

// File: rtl/store_lane_shift.sv
// Combinational lane alignment: positions store data and byte mask across
// two adjacent words and flags stores that spill into the second word.
module store_lane_shift
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [63:0] data64,
    output logic [7:0]  mask8,
    output logic        needs_split
);
    logic [3:0]  mask4;
    logic [31:0] data_m;

    // Bytes above the access size are cleared before shifting so unstrobed lanes carry zero.
    always_comb begin
        mask4  = size_mask(size);
        data_m = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            data_m[8*i +: 8] = mask4[i] ? data[8*i +: 8] : 8'h00;
        end
        data64      = {32'h0000_0000, data_m} << {off, 3'b000};
        mask8       = {4'b0000, mask4} << off;
        needs_split = |mask8[7:4];
    end
endmodule

// File: rtl/store_write_port.sv
// Store write port: accepts one store, lane-aligns it and issues one or two
// registered write beats on the data-memory bus, then pulses done.
module store_write_port
    import lsu_pkg::*;
#(
    parameter logic SPLIT_MISALIGNED = 1'b1
)(
    input  logic               clk,
    input  logic               rst_n,
    store_write_port_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_BEAT0  = ST_BEAT0;
    localparam logic [1:0] S_BEAT1  = ST_BEAT1;
    localparam logic [1:0] S_FINISH = ST_FINISH;

    logic [1:0]  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] hi_data_q, hi_data_d;
    logic [3:0]  hi_strb_q, hi_strb_d;
    logic        split_q, split_d;

    logic [63:0] data64_s;
    logic [7:0]  mask8_s;
    logic        needs_split_s;

    store_lane_shift u_shift (
        .off         (bus.req_addr[1:0]),
        .data        (bus.req_data),
        .size        (bus.req_size),
        .data64      (data64_s),
        .mask8       (mask8_s),
        .needs_split (needs_split_s)
    );

    // Next-state and next-beat computation; the upper half of a split store is parked in hi_*.
    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        hi_data_d   = hi_data_q;
        hi_strb_d   = hi_strb_q;
        split_d     = split_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (needs_split_s && !SPLIT_MISALIGNED) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_BEAT0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = data64_s[31:0];
                        mem_wstrb_d = mask8_s[3:0];
                        hi_data_d   = data64_s[63:32];
                        hi_strb_d   = mask8_s[7:4];
                        split_d     = needs_split_s;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_BEAT0: begin
                if (bus.mem_ready && split_q) begin
                    state_d     = S_BEAT1;
                    mem_addr_d  = mem_addr_q + 32'(WORD_BYTES);
                    mem_wdata_d = hi_data_q;
                    mem_wstrb_d = hi_strb_q;
                end else if (bus.mem_ready) begin
                    state_d     = S_FINISH;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = S_BEAT0;
                end
            end
            S_BEAT1: begin
                if (bus.mem_ready) begin
                    state_d     = S_FINISH;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = S_BEAT1;
                end
            end
            S_FINISH: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State and bus registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hi_data_q   <= 32'h0000_0000;
            hi_strb_q   <= 4'b0000;
            split_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            done_q      <= done_d;
            err_q       <= err_d;
            hi_data_q   <= hi_data_d;
            hi_strb_q   <= hi_strb_d;
            split_q     <= split_d;
        end
    end

    // req_ready is forced low while reset is asserted, even before the first edge.
    assign bus.req_ready = req_ready_q & rst_n;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
